// File: rtl/vram_arbiter.sv
// Shares one synchronous VRAM: display fetches win every cycle (fixed 2-cycle read latency);
// CPU accesses wait in a one-entry holding register; cpu_ready drops while it is full and not being issued.
module vram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 32
) (
  input  logic          pxclk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          cpu_req,
  output logic          cpu_ready,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starve,
  input  logic          starve_clr,
  output logic          vram_en,
  output logic          vram_we,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_wdata,
  input  logic [DW-1:0] vram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;

  logic          pend;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  tag_t          tag0, tag1;
  logic [7:0]    wait_cnt;
  logic          grant_disp, grant_cpu, accept, starve_set;

  assign grant_disp = disp_req;
  assign grant_cpu  = !disp_req && pend;
  // Held low for the whole reset assertion, independent of the holding register state.
  assign cpu_ready  = reset && (!pend || grant_cpu);
  assign accept     = cpu_req && cpu_ready;
  assign starve_set = pend && grant_disp &&
                      (({1'b0, wait_cnt} + 9'd1) >= 9'(STARVE_LIMIT));

  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      pend    <= 1'b0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else if (accept) begin
      pend    <= 1'b1;
      h_we    <= cpu_we;
      h_addr  <= cpu_addr;
      h_wdata <= cpu_wdata;
    end else if (grant_cpu) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      vram_en    <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else if (grant_disp) begin
      vram_en   <= 1'b1;
      vram_we   <= 1'b0;
      vram_addr <= disp_addr;
    end else if (grant_cpu) begin
      vram_en    <= 1'b1;
      vram_we    <= h_we;
      vram_addr  <= h_addr;
      vram_wdata <= h_wdata;
    end else begin
      vram_en <= 1'b0;
      vram_we <= 1'b0;
    end
  end

  // tag0 follows the access on the vram_* outputs, tag1 the data arriving on vram_rdata.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      tag0 <= TAG_NONE;
      tag1 <= TAG_NONE;
    end else begin
      tag1 <= tag0;
      if (grant_disp)
        tag0 <= TAG_DISP;
      else if (grant_cpu && !h_we)
        tag0 <= TAG_CPU;
      else
        tag0 <= TAG_NONE;
    end
  end

  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      disp_rvalid <= (tag1 == TAG_DISP);
      cpu_rvalid  <= (tag1 == TAG_CPU);
      if (tag1 == TAG_DISP)
        disp_rdata <= vram_rdata;
      if (tag1 == TAG_CPU)
        cpu_rdata <= vram_rdata;
    end
  end

  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      cpu_starve <= 1'b0;
    end else begin
      if (pend && grant_disp) begin
        if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
      end else if (grant_cpu) begin
        wait_cnt <= '0;
      end
      // A coincident set beats the clear so a still-starved CPU is never hidden.
      if (starve_set)
        cpu_starve <= 1'b1;
      else if (starve_clr)
        cpu_starve <= 1'b0;
    end
  end

endmodule
